// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port register file with write-to-read bypass and a per-register busy
//   scoreboard used for hazard detection in the pipelined datapath.
//
//   Parameters
//     DATA_W   register width
//     ADDR_W   address width, DEPTH = 2**ADDR_W
//     NRD      number of combinational read ports (1..4)
//     ZERO_REG 1: register 0 reads 0, ignores writes, never goes busy
//
//   Ports
//     clk, rst       clock; synchronous active-high reset
//     ra / rd        packed read addresses / read data, port k in slice k
//     rd_busy        busy bit of the register addressed by each read port
//     we0/wa0/wd0    write port 0 (ALU writeback)
//     we1/wa1/wd1    write port 1 (load writeback, wins over port 0)
//     res_en/res_a   reserve a register at instruction issue
//     wr_conflict    one-cycle pulse: both ports wrote one register last cycle
//     busy_cnt       number of busy registers
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic                  res_en,
  input  logic [ADDR_W-1:0]     res_a,
  output logic                  wr_conflict,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              w0_ok;
  logic              w1_ok;

  function automatic logic is_prot(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writes to the protected register are dropped before they reach any state.
  assign w0_ok = we0 && !is_prot(wa0);
  assign w1_ok = we1 && !is_prot(wa1);

  // Scoreboard next state: writes clear, then a reservation sets, so a
  // reserve and write to the same register in one cycle leaves it busy.
  // NOTE: every variable written here gets a default first; otherwise paths
  // that skip an assignment would infer a latch.
  always_comb begin
    busy_nxt = busy;
    if (w0_ok) busy_nxt[wa0] = 1'b0;
    if (w1_ok) busy_nxt[wa1] = 1'b0;
    if (res_en && !is_prot(res_a)) busy_nxt[res_a] = 1'b1;
  end

  // Population count of the next busy vector, so busy_cnt tracks busy exactly.
  // NOTE: blocking assignments are correct in combinational logic; the running
  // sum must see its own update on each loop iteration.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  // NOTE: the register array is reset explicitly because reset must leave every
  // register reading zero; a memory macro without reset could not be used here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy        <= '0;
      busy_cnt    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (w0_ok) mem[wa0] <= wd0;
      // Port 1 is scheduled last so it overrides port 0 on an address match.
      if (w1_ok) mem[wa1] <= wd1;
      busy        <= busy_nxt;
      busy_cnt    <= cnt_nxt;
      wr_conflict <= w0_ok && w1_ok && (wa0 == wa1);
    end
  end

  // Read ports: protected register, then port 1 bypass, then port 0 bypass,
  // then the array. Bypass is suppressed during reset since no write commits.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (is_prot(ra[k*ADDR_W +: ADDR_W]))
        rd[k*DATA_W +: DATA_W] = '0;
      else if (!rst && we1 && (wa1 == ra[k*ADDR_W +: ADDR_W]))
        rd[k*DATA_W +: DATA_W] = wd1;
      else if (!rst && we0 && (wa0 == ra[k*ADDR_W +: ADDR_W]))
        rd[k*DATA_W +: DATA_W] = wd0;
      else
        rd[k*DATA_W +: DATA_W] = mem[ra[k*ADDR_W +: ADDR_W]];
      // Registered state only; same-cycle clears are handled by forwarding.
      rd_busy[k] = busy[ra[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule
